// File: rtl/data_bus_bridge_pkg.sv
// Shared widths and FSM state type for the MEM-stage data bus bridge.
package data_bus_bridge_pkg;

   localparam int unsigned AddrBus        = 32;
   localparam int unsigned DataBus        = 32;
   localparam int unsigned MemSelBus      = 4;
   localparam int unsigned BridgeStateBus = 3;

   typedef enum logic [BridgeStateBus-1:0] {
      BrIdle  = 3'd0,
      BrReq   = 3'd1,
      BrWait  = 3'd2,
      BrDone  = 3'd3,
      BrDrain = 3'd4
   } bridge_state_e;

endpackage

// File: rtl/data_bus_bridge.sv
// Adapts single-cycle MEM RAM controls to a request/response data bus, stalling the pipeline
// until each access completes and holding the last read word for WB.
module data_bus_bridge
   import data_bus_bridge_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = AddrBus,
   parameter int unsigned DATA_WIDTH = DataBus
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ram_en,
   input  logic [MemSelBus-1:0]  ram_write_en,
   input  logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_write_data,
   input  logic                  flush,
   output logic                  stall_req,
   output logic [DATA_WIDTH-1:0] rdata_out,
   output logic                  bus_req,
   output logic                  bus_wr,
   output logic [MemSelBus-1:0]  bus_wstrb,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_addr_ok,
   input  logic                  bus_data_ok,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   bridge_state_e         state_q, state_d;
   logic                  bus_req_q, bus_req_d;
   logic                  bus_wr_q, bus_wr_d;
   logic [MemSelBus-1:0]  bus_wstrb_q, bus_wstrb_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  launch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BrIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Once the bus has accepted a request it owns the transaction, so a flush must drain it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BrIdle: begin
            if (ram_en && !flush) state_d = BrReq;
         end
         BrReq: begin
            if (bus_addr_ok) begin
               if (bus_data_ok) state_d = flush ? BrIdle : BrDone;
               else             state_d = flush ? BrDrain : BrWait;
            end else if (flush) begin
               state_d = BrIdle;
            end
         end
         BrWait: begin
            if (bus_data_ok)  state_d = flush ? BrIdle : BrDone;
            else if (flush)   state_d = BrDrain;
         end
         BrDone:  state_d = BrIdle;
         BrDrain: begin
            if (bus_data_ok) state_d = BrIdle;
         end
         default: state_d = BrIdle;
      endcase
   end

   assign stall_req = ram_en && (state_q != BrDone) && !flush;
   assign launch    = (state_q == BrIdle) && ram_en && !flush;

   always_comb begin
      bus_req_d   = (state_d == BrReq);
      bus_wr_d    = bus_wr_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      if (launch) begin
         bus_wr_d    = |ram_write_en;
         bus_wstrb_d = ram_write_en;
         bus_addr_d  = ram_addr;
         bus_wdata_d = ram_write_data;
      end
      // DONE is only reached by an unflushed completion, so drained data never lands here.
      if (state_d == BrDone && !bus_wr_q) begin
         rdata_d = bus_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_req_q   <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_wstrb_q <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         bus_req_q   <= bus_req_d;
         bus_wr_q    <= bus_wr_d;
         bus_wstrb_q <= bus_wstrb_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_wr    = bus_wr_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign rdata_out = rdata_q;

endmodule
